// File: rtl/cpu_bus_pkg.sv
// Shared constants for the cpu bus bridge: I/O register offsets and STATUS bit layout.
// The cpu-side software headers mirror these values.
package cpu_bus_pkg;

  localparam logic [3:0] IO_TXDATA = 4'h0;
  localparam logic [3:0] IO_STATUS = 4'h1;
  localparam logic [3:0] IO_RXDATA = 4'h2;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_VALID   = 2;
  localparam int unsigned ST_TX_OVF     = 3;
  localparam int unsigned ST_TX_COUNT   = 8;
  localparam int unsigned ST_TX_COUNT_W = 5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from the entry at the
// read pointer, so it only moves on a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Decodes cpu accesses to block RAM or the I/O page (TX FIFO, RX holding register, STATUS)
// and returns read data with a fixed one-cycle latency for both regions.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned       AWIDTH   = 16,
  parameter int unsigned       DWIDTH   = 16,
  parameter logic [AWIDTH-1:0] IO_BASE  = 16'hFFF0,
  parameter int unsigned       TX_DEPTH = 8,
  parameter int unsigned       TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AWIDTH-1:0]   mem_raddr_i,
  input  logic                mem_rd_i,
  output logic [DWIDTH-1:0]   mem_rdata_o,
  input  logic [AWIDTH-1:0]   mem_waddr_i,
  input  logic [DWIDTH-1:0]   mem_wdata_i,
  input  logic                mem_wr_i,
  output logic [AWIDTH-1:0]   ram_raddr_o,
  input  logic [DWIDTH-1:0]   ram_rdata_i,
  output logic [AWIDTH-1:0]   ram_waddr_o,
  output logic [DWIDTH-1:0]   ram_wdata_o,
  output logic                ram_we_o,
  output logic [TX_WIDTH-1:0] tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [TX_WIDTH-1:0] rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o
);

  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  function automatic logic io_hit(input logic [AWIDTH-1:0] a);
    return a[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4];
  endfunction

  logic                rd_io, wr_io;
  logic [3:0]          roff, woff;
  logic                tx_push, tx_pop, tx_drop, tx_full, tx_empty;
  logic [CW-1:0]       tx_count;
  logic                ovf_q, ovf_d, ovf_clr;
  logic                rx_valid_q, rx_valid_d, rx_capture, rx_clear;
  logic [TX_WIDTH-1:0] rx_data_q;
  logic                sel_io_q;
  logic [DWIDTH-1:0]   io_rdata_q, io_rdata_d, status;

  assign rd_io = mem_rd_i & io_hit(mem_raddr_i);
  assign wr_io = mem_wr_i & io_hit(mem_waddr_i);
  assign roff  = mem_raddr_i[3:0];
  assign woff  = mem_waddr_i[3:0];

  assign ram_raddr_o = mem_raddr_i;
  assign ram_waddr_o = mem_waddr_i;
  assign ram_wdata_o = mem_wdata_i;
  assign ram_we_o    = mem_wr_i & ~io_hit(mem_waddr_i);

  assign tx_push    = wr_io & (woff == IO_TXDATA);
  assign tx_valid_o = ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign tx_drop    = tx_push & tx_full & ~tx_pop;
  assign ovf_clr    = wr_io & (woff == IO_STATUS) & mem_wdata_i[ST_TX_OVF];

  sync_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (TX_WIDTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (mem_wdata_i[TX_WIDTH-1:0]),
    .pop       (tx_pop),
    .head      (tx_data_o),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign rx_ready_o = ~rx_valid_q;
  assign rx_capture = rx_valid_i & ~rx_valid_q;
  // Reading RXDATA consumes the byte; capture and clear are exclusive via rx_valid_q.
  assign rx_clear   = rd_io & (roff == IO_RXDATA) & rx_valid_q;

  always_comb begin
    status                                   = '0;
    status[ST_TX_FULL]                       = tx_full;
    status[ST_TX_EMPTY]                      = tx_empty;
    status[ST_RX_VALID]                      = rx_valid_q;
    status[ST_TX_OVF]                        = ovf_q;
    status[ST_TX_COUNT +: ST_TX_COUNT_W]     = ST_TX_COUNT_W'(tx_count);
  end

  always_comb begin
    io_rdata_d = '0;
    if (rd_io) begin
      case (roff)
        IO_STATUS: io_rdata_d = status;
        IO_RXDATA: if (rx_valid_q) io_rdata_d[TX_WIDTH-1:0] = rx_data_q;
        default:   io_rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (tx_drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    rx_valid_d = rx_valid_q;
    if (rx_capture) begin
      rx_valid_d = 1'b1;
    end else if (rx_clear) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      sel_io_q   <= rd_io;
      io_rdata_q <= io_rdata_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      if (rx_capture) begin
        rx_data_q <= rx_data_i;
      end
    end
  end

  assign mem_rdata_o = sel_io_q ? io_rdata_q : ram_rdata_i;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Scoreboard bench for cpu_bus_bridge: directed scenarios plus random traffic checked against
// a queue-based behavioural model of RAM, TX FIFO, RX register and STATUS.
module tb_cpu_bus_bridge;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_raddr_i, mem_waddr_i, mem_wdata_i, mem_rdata_o;
  logic        mem_rd_i, mem_wr_i;
  logic [15:0] ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_rdata;
  logic        ram_we_o;
  logic [7:0]  tx_data_o, rx_data_i;
  logic        tx_valid_o, tx_ready_i, rx_valid_i, rx_ready_o;

  always #5 clk = ~clk;

  cpu_bus_bridge #(
    .AWIDTH   (16),
    .DWIDTH   (16),
    .IO_BASE  (16'hFFF0),
    .TX_DEPTH (DEPTH),
    .TX_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_raddr_i (mem_raddr_i),
    .mem_rd_i    (mem_rd_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wr_i    (mem_wr_i),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o)
  );

  // Environment block RAM: synchronous read of the old contents, then write.
  logic [15:0] ram_mem [65536];
  initial for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0000;
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_raddr_o];
    if (ram_we_o) ram_mem[ram_waddr_o] = ram_wdata_o;
  end

  // Reference model state
  logic [7:0]  m_txq[$];
  logic        m_ovf, m_rx_full;
  logic [7:0]  m_rx_byte;
  logic [15:0] m_ram [logic [15:0]];

  logic [15:0] rd_exp[$];
  logic [15:0] rd_e;
  logic        cyc_valid = 1'b0;
  logic        exp_we, exp_tx_valid, exp_rx_ready;
  logic [7:0]  exp_head;
  logic [15:0] exp_waddr, exp_wdata;
  logic [7:0]  seen[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    int n;
    n = m_txq.size();
    return {3'b000, 5'(n), 4'b0000, m_ovf, m_rx_full, n == 0, n == DEPTH};
  endfunction

  // Apply one cycle of cpu/peripheral inputs, record expectations, advance the model.
  task automatic drive(input logic rd, input logic [15:0] ra, input logic wr,
                       input logic [15:0] wa, input logic [15:0] wd, input logic txr,
                       input logic rxv, input logic [7:0] rxd);
    logic        io_r, io_w, pop, push;
    logic [15:0] e;
    mem_rd_i = rd; mem_raddr_i = ra; mem_wr_i = wr; mem_waddr_i = wa; mem_wdata_i = wd;
    tx_ready_i = txr; rx_valid_i = rxv; rx_data_i = rxd;
    io_r = rd && (ra[15:4] == 12'hFFF);
    io_w = wr && (wa[15:4] == 12'hFFF);
    e = 16'h0000;
    if (io_r) begin
      if (ra[3:0] == 4'h1) e = m_status();
      else if (ra[3:0] == 4'h2 && m_rx_full) e = {8'h00, m_rx_byte};
    end else begin
      e = m_ram.exists(ra) ? m_ram[ra] : 16'h0000;
    end
    rd_exp.push_back(e);
    exp_we = wr && !io_w; exp_waddr = wa; exp_wdata = wd;
    exp_tx_valid = m_txq.size() > 0;
    exp_head = exp_tx_valid ? m_txq[0] : 8'h00;
    exp_rx_ready = !m_rx_full;
    cyc_valid = 1'b1;
    pop = txr && m_txq.size() > 0;
    push = io_w && wa[3:0] == 4'h0;
    if (pop) void'(m_txq.pop_front());
    if (push) begin
      if (m_txq.size() < DEPTH) m_txq.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end else if (io_w && wa[3:0] == 4'h1 && wd[3]) begin
      m_ovf = 1'b0;
    end
    if (rxv && !m_rx_full) begin
      m_rx_full = 1'b1; m_rx_byte = rxd;
    end else if (io_r && ra[3:0] == 4'h2 && m_rx_full) begin
      m_rx_full = 1'b0;
    end
    if (exp_we) m_ram[wa] = wd;
    @(posedge clk);
    #2;
    cyc_valid = 1'b0;
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [15:0] d, input logic txr);
    drive(1'b1, 16'h0000, 1'b1, a, d, txr, 1'b0, 8'h00);
  endtask

  task automatic rd_reg(input logic [15:0] a, input logic txr);
    drive(1'b1, a, 1'b0, 16'h0000, 16'h0000, txr, 1'b0, 8'h00);
  endtask

  task automatic idle_inputs();
    mem_rd_i = 1'b1; mem_raddr_i = 16'h0000; mem_wr_i = 1'b0; mem_waddr_i = 16'h0000;
    mem_wdata_i = 16'h0000; tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
  endtask

  task automatic model_reset();
    m_txq.delete(); m_ovf = 1'b0; m_rx_full = 1'b0; rd_exp.delete(); cyc_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(0, 2) == 0) return 16'h0100 + 16'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 0) return 16'hFFF0;
    return 16'hFFF0 + 16'($urandom_range(0, 15));
  endfunction

  // Read-data monitor: one result per issued read, one cycle later.
  always @(posedge clk) begin
    #1;
    if (rst_n && rd_exp.size() > 0) begin
      rd_e = rd_exp.pop_front();
      chk("rdata", mem_rdata_o, rd_e);
    end
  end

  // Combinational/handshake monitor for the cycle currently being driven.
  always @(negedge clk) begin
    if (rst_n && cyc_valid) begin
      chk("ram_we", ram_we_o, exp_we);
      if (exp_we) begin
        chk("ram_waddr", ram_waddr_o, exp_waddr);
        chk("ram_wdata", ram_wdata_o, exp_wdata);
      end
      chk("tx_valid", tx_valid_o, exp_tx_valid);
      if (exp_tx_valid) chk("tx_head", tx_data_o, exp_head);
      chk("rx_ready", rx_ready_o, exp_rx_ready);
      if (tx_valid_o && tx_ready_i) seen.push_back(tx_data_o);
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    apply_reset();
    chk("rst tx_valid", tx_valid_o, 0);
    chk("rst tx_data", tx_data_o, 0);
    chk("rst rx_ready", rx_ready_o, 1);
    chk("rst rdata", mem_rdata_o, 0);

    // RAM path then STATUS read
    drive(1'b1, 16'h0000, 1'b1, 16'h0040, 16'h1234, 1'b0, 1'b0, 8'h00);
    rd_reg(16'h0040, 1'b0);
    chk("ram read", mem_rdata_o, 16'h1234);
    rd_reg(16'hFFF1, 1'b0);
    chk("status idle", mem_rdata_o, 16'h0002);

    // TX fill with one overflowing push, then drain
    for (int i = 1; i <= 9; i++) wr_reg(16'hFFF0, 16'(i), 1'b0);
    rd_reg(16'hFFF1, 1'b0);
    chk("status full+ovf", mem_rdata_o, 16'h0809);
    chk("head first", tx_data_o, 8'h01);
    seen.delete();
    for (int i = 0; i < 8; i++) rd_reg(16'h0000, 1'b1);
    chk("drain count", seen.size(), 8);
    for (int i = 0; i < 8; i++) if (i < seen.size()) chk("drain order", seen[i], i + 1);
    chk("drain tx_valid", tx_valid_o, 0);

    // Refill, clear overflow, push+pop at full, dropped push re-sets overflow
    for (int i = 0; i < 8; i++) wr_reg(16'hFFF0, 16'h0010 + 16'(i), 1'b0);
    wr_reg(16'hFFF1, 16'h0008, 1'b0);
    rd_reg(16'hFFF1, 1'b0);
    chk("ovf cleared", mem_rdata_o, 16'h0801);
    seen.delete();
    wr_reg(16'hFFF0, 16'h00AA, 1'b1);
    rd_reg(16'hFFF1, 1'b0);
    chk("push+pop full", mem_rdata_o, 16'h0801);
    wr_reg(16'hFFF0, 16'h0008, 1'b0);
    rd_reg(16'hFFF1, 1'b0);
    chk("drop sets ovf", mem_rdata_o, 16'h0809);
    for (int i = 0; i < 8; i++) rd_reg(16'h0000, 1'b1);
    chk("drain2 count", seen.size(), 9);
    if (seen.size() == 9) begin
      chk("drain2 first", seen[1], 8'h11);
      chk("drain2 last", seen[8], 8'hAA);
    end
    wr_reg(16'hFFF1, 16'h0008, 1'b0);

    // RX capture, read, clear
    drive(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h5A);
    chk("rx_ready held", rx_ready_o, 0);
    rd_reg(16'hFFF1, 1'b0);
    chk("status rx", mem_rdata_o, 16'h0006);
    rd_reg(16'hFFF2, 1'b0);
    chk("rx data", mem_rdata_o, 16'h005A);
    chk("rx_ready freed", rx_ready_o, 1);
    rd_reg(16'hFFF2, 1'b0);
    chk("rx empty read", mem_rdata_o, 16'h0000);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) != 0, pick_addr(), $urandom_range(0, 1) == 0, pick_addr(),
            16'($urandom), (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 3) == 0, 8'($urandom));
    end

    // Asynchronous reset mid-burst
    apply_reset();
    for (int i = 0; i < 3; i++) wr_reg(16'hFFF0, 16'h0030 + 16'(i), 1'b0);
    drive(1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 8'h77);
    chk("pre-reset tx_valid", tx_valid_o, 1);
    chk("pre-reset rx_ready", rx_ready_o, 0);
    #1 rst_n = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    chk("async tx_valid", tx_valid_o, 0);
    chk("async rx_ready", rx_ready_o, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rd_reg(16'hFFF1, 1'b0);
    chk("post-reset status", mem_rdata_o, 16'h0002);
    rd_reg(16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
Sits directly downstream of the cpu memory port. It decodes each cpu access to either on-chip block RAM or a small memory-mapped I/O page, and returns read data with the fixed 1-cycle latency the cpu expects. The I/O page contains a TX FIFO toward a byte-stream peripheral (e.g. UART), a single-entry RX holding register, and a status register. The cpu has no stall input, so every access completes without wait states.

Parameters:
AWIDTH, 16, cpu address width
DWIDTH, 16, cpu data width
IO_BASE, 16'hFFF0, base of the I/O page; low 4 address bits select the register
TX_DEPTH, 8, TX FIFO entries; must be a power of two, 2..16
TX_WIDTH, 8, TX/RX payload width; payload is taken from wdata[TX_WIDTH-1:0]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_raddr_i  in  AWIDTH  cpu read address
mem_rd_i  in  1  cpu read strobe (the cpu drives it high constantly)
mem_rdata_o  out  DWIDTH  read data, valid 1 cycle after the address
mem_waddr_i  in  AWIDTH  cpu write address
mem_wdata_i  in  DWIDTH  cpu write data
mem_wr_i  in  1  cpu write strobe
ram_raddr_o  out  AWIDTH  RAM read address (pass-through)
ram_rdata_i  in  DWIDTH  RAM synchronous read data (1-cycle latency)
ram_waddr_o  out  AWIDTH  RAM write address (pass-through)
ram_wdata_o  out  DWIDTH  RAM write data (pass-through)
ram_we_o  out  1  RAM write enable
tx_data_o  out  TX_WIDTH  FIFO head
tx_valid_o  out  1  FIFO non-empty
tx_ready_i  in  1  peripheral accepts the head
rx_data_i  in  TX_WIDTH  incoming byte
rx_valid_i  in  1  incoming byte valid
rx_ready_o  out  1  RX holding register empty

Behaviour:
- Clock and reset: single clock domain. rst_n is asynchronous, active-low, and is fully decided as such.
- Address decode: io_hit(a) = (a[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]). Registers:
  - +0 TXDATA (W)
  - +1 STATUS (R/W)
  - +2 RXDATA (R)
  - all other offsets read 0, writes ignored.
- RAM writes: ram_we_o = mem_wr_i & ~io_hit(mem_waddr_i), combinational. Address and data are straight pass-through.
- Read path:
  - sel_io_q <= mem_rd_i & io_hit(mem_raddr_i).
  - io_rdata_q <= the decoded register value in the same cycle.
  - mem_rdata_o = sel_io_q ? io_rdata_q : ram_rdata_i.
  - Latency is exactly 1 cycle for both regions.
- STATUS bit fields, zero-extended to DWIDTH:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_valid
  - [3] tx_overflow (sticky)
  - [8 +: 5] tx_count
- STATUS write: writing 1 to bit 3 clears tx_overflow. All other bits are ignored.
- TX push: a write to TXDATA pushes wdata[TX_WIDTH-1:0].
  - Accepted if count < TX_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the data is dropped and tx_overflow is set.
  - A set caused by a dropped push takes priority over a same-cycle clear.
- TX pop: occurs when tx_valid_o & tx_ready_i. tx_data_o is the registered head; it is stable while tx_valid_o is high and not popped.
- TX simultaneous events:
  - Push and pop together: count is unchanged.
  - Empty with a push: tx_valid_o rises the next cycle (no fall-through).
- TX pointers: wrap modulo TX_DEPTH; count ranges 0..TX_DEPTH.
- RX capture: when rx_valid_i & rx_ready_o, the byte is captured and rx_valid is set; rx_ready_o = ~rx_valid.
- RX read:
  - A read of RXDATA (mem_rd_i high, raddr hits +2) returns the held byte zero-extended.
  - If rx_valid is set, the same read clears it at that cycle's edge.
  - A read while empty returns 0 and has no side effect.
  - A new byte cannot be captured in the same cycle as the pop, because rx_ready_o is still low.
- Reset values:
  - TX FIFO empty; tx_valid_o=0; tx_overflow=0.
  - rx_valid=0, so rx_ready_o=1.
  - sel_io_q=0, so mem_rdata_o follows ram_rdata_i; io_rdata_q=0.
  - tx_data_o=0.
- Reset mid-operation: all FIFO contents and the held RX byte are discarded. The peripheral must tolerate tx_valid_o dropping without a handshake.

Decomposition:
- Shared package cpu_bus_pkg holds the I/O register offsets (IO_TXDATA, IO_STATUS, IO_RXDATA) and the STATUS bit positions. The cpu-side software headers use the same values.
- One sub-module, sync_fifo (parameters DEPTH and WIDTH; push/pop, full/empty/count outputs, asynchronous active-low reset), instantiated for TX.
- Decode, RX register and read mux live in the top module.

Test Plan:
- RAM path: write 16'h1234 to 16'h0040, then read 16'h0040 → ram_we_o pulses once, and mem_rdata_o=16'h1234 exactly 1 cycle after the address; a read of 16'hFFF1 issued the next cycle returns STATUS 16'h0002 with no RAM write.
- TX fill/overflow: tx_ready_i=0, write 9 bytes 8'h01..8'h09 to 16'hFFF0 → STATUS reads 16'h0809 (count 8, full, overflow); then raise tx_ready_i → tx_data_o emits 01..08 in order, and tx_valid_o falls after the 8th.
- TX simultaneous: with FIFO full and tx_ready_i=1, push 8'hAA in the same cycle as a pop → no overflow, count stays 8, and 8'hAA emerges last.
- Overflow clear: with overflow set, write 16'h0008 to 16'hFFF1 → bit 3 reads 0; a write of 16'h0008 coinciding with a dropped push → bit 3 stays 1.
- RX: drive 8'h5A with rx_valid_i → rx_ready_o=0 and STATUS bit 2 = 1; read 16'hFFF2 → returns 16'h005A; next cycle rx_ready_o=1; a second read returns 16'h0000.
- Async reset: assert rst_n low mid-burst with 3 entries queued and no clock edge → tx_valid_o=0 and rx_ready_o=1 immediately; after release, STATUS=16'h0002.
